vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, 25.175 MHz pixel clock; the only clock.
REQ-010 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-011 SHALL have port int_en, input, 1, enables the vblank interrupt request.
REQ-012 SHALL have port int_ack, input, 1, one-cycle CPU interrupt-acknowledge pulse.
REQ-013 SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-014 SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-015 SHALL have port de, output, 1, display enable, high in the visible area.
REQ-016 SHALL have port x, output, 10, visible pixel column.
REQ-017 SHALL have port y, output, 10, visible line.
REQ-018 SHALL have port frame_start, output, 1, one-cycle pulse at (0,0).
REQ-019 SHALL have port int_n, output, 1, Z80 interrupt request, active-low, level.
REQ-020 SHALL have port overrun, output, 8, count of vblank events raised while an interrupt was still pending.

Function
REQ-021 SHALL keep a horizontal counter h of 0..H_TOTAL-1, where H_TOTAL is the sum of the four H parameters (800 at default), incrementing every clk and wrapping to 0.
REQ-022 SHALL keep a vertical counter v of 0..V_TOTAL-1 (V_TOTAL 525 at default), incrementing only when h wraps; v SHALL wrap to 0 when h and v are both at maximum.
REQ-023 SHALL register all outputs, with exactly 1 cycle of latency from the counter state they describe.
REQ-024 SHALL drive hsync=0 iff h is in H_VISIBLE+H_FRONT .. H_VISIBLE+H_FRONT+H_SYNC-1 (656..751 at default).
REQ-025 SHALL drive vsync=0 iff v is in V_VISIBLE+V_FRONT .. +V_SYNC-1 (490..491 at default).
REQ-026 SHALL drive de=1 iff h<H_VISIBLE and v<V_VISIBLE; x=h and y=v when de=1; x=0 and y=0 when de=0.
REQ-027 SHALL pulse frame_start high for one cycle for counter state h=0,v=0.
REQ-028 SHALL define the vblank event as counter state h=0,v=V_VISIBLE.
REQ-029 SHALL drive int_n to 0 on a vblank event when int_en=1, and hold it there until int_ack.
REQ-030 SHALL return int_n to 1 on int_ack while pending; int_ack while not pending SHALL be ignored.
REQ-031 SHALL keep int_n=0 (new request wins) when int_ack and a vblank event coincide, and SHALL NOT increment overrun.
REQ-032 SHALL increment overrun on a vblank event while int_n=0 without int_ack; overrun SHALL saturate at 255.
REQ-033 SHALL leave a pending int_n unaffected by int_en=0; int_en SHALL gate only new requests.

Reset
REQ-034 SHALL, on reset=0 at a clk edge, set h=0, v=0, hsync=1, vsync=1, de=0, x=0, y=0, frame_start=0, int_n=1, overrun=0.
REQ-035 SHALL apply reset mid-frame or mid-interrupt immediately, discarding any pending request.
REQ-036 SHALL, on the first cycle after reset release, have counters at (0,0), with the frame_start/de outputs for (0,0) appearing one cycle later.

Structure
REQ-037 SHALL take default timing constants and the H_TOTAL/V_TOTAL derivations from a shared package vga_pkg, which the top level and testbench also use.
REQ-038 SHALL instantiate one sub-module, wrap_counter (parameterised modulus, enable in, wrap-carry out), twice: once for h and once for v.

Verification
REQ-039 SHALL verify: release reset, run 2 frames -> frame_start period 420000 clk; hsync low 96 clk every 800; vsync low 1600 clk every 420000.
REQ-040 SHALL verify: first visible pixel after reset -> de=1, x=0, y=0 on the 2nd cycle after release; last visible pixel -> x=639, y=479, then de=0.
REQ-041 SHALL verify: int_en=1, no ack -> int_n falls at line 480 and stays 0; after 3 further frames, overrun=3.
REQ-042 SHALL verify: int_ack on the same cycle as a vblank event with int_n=0 -> int_n stays 0 and overrun is unchanged; int_ack on a later cycle -> int_n=1 next cycle.
REQ-043 SHALL verify: reset=0 at h=700, v=300 with int_n=0 and overrun=5 -> all outputs are at reset values after one edge and timing restarts from (0,0).
REQ-044 SHALL verify: force overrun to 255 via 256+ missed frames -> overrun holds at 255.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals and the registered output bundle.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned OVR_W   = 8;

  localparam int unsigned H_VISIBLE_D = 640;
  localparam int unsigned H_FRONT_D   = 16;
  localparam int unsigned H_SYNC_D    = 96;
  localparam int unsigned H_BACK_D    = 48;
  localparam int unsigned V_VISIBLE_D = 480;
  localparam int unsigned V_FRONT_D   = 10;
  localparam int unsigned V_SYNC_D    = 2;
  localparam int unsigned V_BACK_D    = 33;

  function automatic int unsigned span_total(input int unsigned vis, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  localparam int unsigned H_TOTAL_D = span_total(H_VISIBLE_D, H_FRONT_D, H_SYNC_D, H_BACK_D);
  localparam int unsigned V_TOTAL_D = span_total(V_VISIBLE_D, V_FRONT_D, V_SYNC_D, V_BACK_D);

  typedef struct packed {
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               frame_start;
    logic               int_n;
    logic [OVR_W-1:0]   overrun;
  } vga_out_t;

  localparam vga_out_t VGA_OUT_RESET = '{
    hsync: 1'b1, vsync: 1'b1, de: 1'b0, x: '0, y: '0,
    frame_start: 1'b0, int_n: 1'b1, overrun: '0
  };

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD up-counter; wrap_c flags the enabled step that returns it to zero.
module wrap_counter #(
  parameter int unsigned MOD = 800,
  parameter int unsigned W   = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap_c
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap_c = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      count <= wrap_c ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA sync/raster generator with a Z80-style vblank interrupt and overrun count.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_D,
  parameter int unsigned H_FRONT   = H_FRONT_D,
  parameter int unsigned H_SYNC    = H_SYNC_D,
  parameter int unsigned H_BACK    = H_BACK_D,
  parameter int unsigned V_VISIBLE = V_VISIBLE_D,
  parameter int unsigned V_FRONT   = V_FRONT_D,
  parameter int unsigned V_SYNC    = V_SYNC_D,
  parameter int unsigned V_BACK    = V_BACK_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               int_en,
  input  logic               int_ack,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frame_start,
  output logic               int_n,
  output logic [OVR_W-1:0]   overrun
);

  localparam int unsigned H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [COORD_W-1:0] H_VIS_END = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] HS_START  = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END    = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] V_VIS_END = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] VS_START  = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END    = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [OVR_W-1:0]   OVR_MAX   = {OVR_W{1'b1}};

  logic [COORD_W-1:0] h;
  logic [COORD_W-1:0] v;
  logic               h_wrap_c;
  logic               v_wrap_c;
  logic               vis_c;
  logic               vblank_c;
  logic               at_origin;
  vga_out_t           q;

  wrap_counter #(.MOD(H_TOTAL), .W(COORD_W)) u_h_cnt (
    .clk(clk), .reset(reset), .en(1'b1), .count(h), .wrap_c(h_wrap_c)
  );

  wrap_counter #(.MOD(V_TOTAL), .W(COORD_W)) u_v_cnt (
    .clk(clk), .reset(reset), .en(h_wrap_c), .count(v), .wrap_c(v_wrap_c)
  );

  assign vis_c    = (h < H_VIS_END) && (v < V_VIS_END);
  assign vblank_c = (h == '0) && (v == V_VIS_END);

  // at_origin is high while the counters sit at (0,0); frame_start is its registered copy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q         <= VGA_OUT_RESET;
      at_origin <= 1'b1;
    end else begin
      at_origin     <= v_wrap_c;
      q.hsync       <= !((h >= HS_START) && (h < HS_END));
      q.vsync       <= !((v >= VS_START) && (v < VS_END));
      q.de          <= vis_c;
      q.x           <= vis_c ? h : '0;
      q.y           <= vis_c ? v : '0;
      q.frame_start <= at_origin;
      if (vblank_c && !q.int_n && !int_ack && (q.overrun != OVR_MAX)) begin
        q.overrun <= q.overrun + OVR_W'(1);
      end
      // A fresh request beats a coincident acknowledge.
      if (vblank_c && int_en) begin
        q.int_n <= 1'b0;
      end else if (int_ack) begin
        q.int_n <= 1'b1;
      end
    end
  end

  assign hsync       = q.hsync;
  assign vsync       = q.vsync;
  assign de          = q.de;
  assign x           = q.x;
  assign y           = q.y;
  assign frame_start = q.frame_start;
  assign int_n       = q.int_n;
  assign overrun     = q.overrun;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing on a shrunken raster; expectations come from cycle arithmetic.
module tb_vga_timing;
  import vga_pkg::*;

  localparam int unsigned TH_VIS = 6, TH_FRONT = 1, TH_SYNC = 2, TH_BACK = 1;
  localparam int unsigned TV_VIS = 4, TV_FRONT = 1, TV_SYNC = 1, TV_BACK = 2;
  localparam int HT = int'(span_total(TH_VIS, TH_FRONT, TH_SYNC, TH_BACK));
  localparam int VT = int'(span_total(TV_VIS, TV_FRONT, TV_SYNC, TV_BACK));
  localparam int FR = HT * VT;

  logic               clk = 1'b0;
  logic               reset;
  logic               int_en;
  logic               int_ack;
  logic               hsync, vsync, de, frame_start, int_n;
  logic [COORD_W-1:0] x, y;
  logic [OVR_W-1:0]   overrun;

  vga_timing #(
    .H_VISIBLE(TH_VIS), .H_FRONT(TH_FRONT), .H_SYNC(TH_SYNC), .H_BACK(TH_BACK),
    .V_VISIBLE(TV_VIS), .V_FRONT(TV_FRONT), .V_SYNC(TV_SYNC), .V_BACK(TV_BACK)
  ) dut (
    .clk(clk), .reset(reset), .int_en(int_en), .int_ack(int_ack),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .int_n(int_n), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    vga_out_t o;
    bit       rst;
  } item_t;

  item_t sb[$];
  int    compared   = 0;
  int    mismatched = 0;

  // Reference state: cycle position inside the frame plus interrupt bookkeeping.
  int t     = 0;
  bit mpend = 0;
  int movr  = 0;

  task automatic apply(input bit r, input bit e, input bit a);
    item_t it;
    int    hh, vv;
    bit    vbl;
    reset   = r;
    int_en  = e;
    int_ack = a;
    it.rst  = !r;
    if (!r) begin
      it.o  = VGA_OUT_RESET;
      t     = 0;
      mpend = 0;
      movr  = 0;
    end else begin
      hh = t % HT;
      vv = t / HT;
      it.o.hsync = !(hh >= int'(TH_VIS + TH_FRONT) && hh < int'(TH_VIS + TH_FRONT + TH_SYNC));
      it.o.vsync = !(vv >= int'(TV_VIS + TV_FRONT) && vv < int'(TV_VIS + TV_FRONT + TV_SYNC));
      it.o.de    = (hh < int'(TH_VIS)) && (vv < int'(TV_VIS));
      it.o.x     = it.o.de ? COORD_W'(hh) : '0;
      it.o.y     = it.o.de ? COORD_W'(vv) : '0;
      it.o.frame_start = (t == 0);
      vbl = (t == int'(TV_VIS) * HT);
      if (vbl && mpend && !a && movr < 255) movr++;
      if (vbl && e) mpend = 1;
      else if (a) mpend = 0;
      it.o.int_n   = !mpend;
      it.o.overrun = OVR_W'(movr);
      t = (t + 1) % FR;
    end
    sb.push_back(it);
  endtask

  task automatic step(input bit r, input bit e, input bit a);
    @(negedge clk);
    apply(r, e, a);
  endtask

  // Monitor: pop one expectation per edge, plus sync/frame period checks on the live outputs.
  item_t    mon_it;
  vga_out_t act;
  int cyc = 0, last_fs = -1, last_hf = -1, hlow = 0, vlow = 0;
  bit hval = 0, vval = 0, prev_h = 1, prev_v = 1;

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_it = sb.pop_front();
      act = '{hsync: hsync, vsync: vsync, de: de, x: x, y: y,
              frame_start: frame_start, int_n: int_n, overrun: overrun};
      compared++;
      if (act !== mon_it.o) begin
        mismatched++;
        $display("FAIL outputs cyc=%0d actual hs=%b vs=%b de=%b x=%0d y=%0d fs=%b int_n=%b ovr=%0d required hs=%b vs=%b de=%b x=%0d y=%0d fs=%b int_n=%b ovr=%0d",
                 cyc, act.hsync, act.vsync, act.de, act.x, act.y, act.frame_start, act.int_n, act.overrun,
                 mon_it.o.hsync, mon_it.o.vsync, mon_it.o.de, mon_it.o.x, mon_it.o.y,
                 mon_it.o.frame_start, mon_it.o.int_n, mon_it.o.overrun);
      end
      if (mon_it.rst) begin
        last_fs = -1; last_hf = -1; hval = 0; vval = 0; hlow = 0; vlow = 0;
        prev_h = 1; prev_v = 1;
      end else begin
        if (frame_start) begin
          if (last_fs >= 0) begin
            compared++;
            if (cyc - last_fs != FR) begin
              mismatched++;
              $display("FAIL frame_period actual=%0d required=%0d", cyc - last_fs, FR);
            end
          end
          last_fs = cyc;
        end
        if (!hsync) begin
          if (prev_h) begin
            if (last_hf >= 0) begin
              compared++;
              if (cyc - last_hf != HT) begin
                mismatched++;
                $display("FAIL hsync_period actual=%0d required=%0d", cyc - last_hf, HT);
              end
            end
            last_hf = cyc; hval = 1; hlow = 0;
          end
          hlow++;
        end else if (!prev_h && hval) begin
          compared++;
          if (hlow != int'(TH_SYNC)) begin
            mismatched++;
            $display("FAIL hsync_width actual=%0d required=%0d", hlow, TH_SYNC);
          end
        end
        if (!vsync) begin
          if (prev_v) begin vval = 1; vlow = 0; end
          vlow++;
        end else if (!prev_v && vval) begin
          compared++;
          if (vlow != int'(TV_SYNC) * HT) begin
            mismatched++;
            $display("FAIL vsync_width actual=%0d required=%0d", vlow, int'(TV_SYNC) * HT);
          end
        end
        prev_h = hsync;
        prev_v = vsync;
      end
      cyc++;
    end
  end

  initial begin
    apply(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    // Free-running frames with requests enabled and never acknowledged.
    repeat (4 * FR) step(1, 1, 0);
    // Acknowledge coinciding with a vblank, then a lone acknowledge later.
    while (t != int'(TV_VIS) * HT) step(1, 1, 0);
    step(1, 1, 1);
    repeat (7) step(1, 1, 0);
    step(1, 1, 1);
    repeat (FR) step(1, 0, 0);
    // Randomised enable/acknowledge traffic.
    repeat (6 * FR) step(1, bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 7) == 0));
    // Build overrun=5 with a pending request, then reset mid-line in the sync pulse.
    step(0, 0, 0);
    repeat (6 * FR) step(1, 1, 0);
    while (t != 2 * HT + 8) step(1, 1, 0);
    step(0, 1, 0);
    repeat (2 * FR) step(1, 0, 0);
    // Long run of missed vblanks to drive overrun into saturation.
    repeat (260 * FR) step(1, 1, 0);
    repeat (20) step(1, 1, bit'($urandom_range(0, 3) == 0));
    repeat (3) @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain actual=%0d left required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
